// File: rtl/seq_controller.sv
// seq_controller: FRIDA ADC array conversion sequencer (phase strobes, bursts).
// Optional build define SEQ_CAPTURE_EN enables comparator decision capture.
module seq_controller #(
   parameter int NBITS = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_t_init,
   input  logic [CNT_W-1:0] cfg_t_samp,
   input  logic [CNT_W-1:0] cfg_t_comp,
   input  logic [CNT_W-1:0] cfg_t_logic,
   input  logic [4:0]       cfg_ncycles,
   input  logic [7:0]       cfg_nconv,
   input  logic             comp_in,
   output logic             seq_init,
   output logic             seq_samp,
   output logic             seq_comp,
   output logic             seq_logic,
   output logic             busy,
   output logic             done,
   output logic [NBITS-1:0] result,
   output logic             result_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_SAMP,
      S_COMP,
      S_LOGIC,
      S_GAP
   } state_t;

   localparam logic [4:0]       NB_MAX  = 5'(NBITS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   state_t           state_n;
   state_t           nxt;
   state_t           nxt_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [4:0]       cyc;
   logic [4:0]       cyc_n;
   logic [4:0]       cyc_inc;
   logic [7:0]       conv;
   logic [7:0]       conv_n;
   logic [7:0]       conv_inc;

   logic [CNT_W-1:0] sh_t_init;
   logic [CNT_W-1:0] sh_t_samp;
   logic [CNT_W-1:0] sh_t_comp;
   logic [CNT_W-1:0] sh_t_logic;
   logic [4:0]       sh_ncycles;
   logic [7:0]       sh_nconv;

   logic [4:0]       ncyc_eff;
   logic [CNT_W-1:0] t_cur;
   logic             phase_end;
   logic             load;
   logic             cap_shift;
   logic             cap_clr;
   logic             rv_n;
   logic             done_n;

   assign cyc_inc   = cyc + 5'd1;
   assign conv_inc  = conv + 8'd1;
   assign phase_end = (cnt == t_cur);

   // clamp pairs per conversion into 1..NBITS
   always_comb begin
      ncyc_eff = sh_ncycles;
      if (sh_ncycles == 5'd0)
         ncyc_eff = 5'd1;
      else if (sh_ncycles > NB_MAX)
         ncyc_eff = NB_MAX;
   end

   // programmed length-1 of the phase currently running
   always_comb begin
      t_cur = '0;
      unique case (state)
         S_INIT:  t_cur = sh_t_init;
         S_SAMP:  t_cur = sh_t_samp;
         S_COMP:  t_cur = sh_t_comp;
         S_LOGIC: t_cur = sh_t_logic;
         default: t_cur = '0;
      endcase
   end

   // next-state, counters and conversion/run bookkeeping
   always_comb begin
      state_n   = state;
      nxt_n     = nxt;
      cnt_n     = cnt;
      cyc_n     = cyc;
      conv_n    = conv;
      load      = 1'b0;
      cap_shift = 1'b0;
      cap_clr   = 1'b0;
      rv_n      = 1'b0;
      done_n    = 1'b0;
      if (state == S_IDLE) begin
         if (start && !abort) begin
            load    = 1'b1;
            state_n = S_INIT;
            cnt_n   = '0;
            cyc_n   = '0;
            conv_n  = '0;
            cap_clr = 1'b1;
         end
      end else if (abort) begin
         state_n = S_IDLE;
         cnt_n   = '0;
         cyc_n   = '0;
      end else if (state == S_GAP) begin
         state_n = nxt;
         cnt_n   = '0;
         cap_clr = (nxt == S_INIT);
      end else if (!phase_end) begin
         cnt_n = cnt + CNT_ONE;
      end else begin
         cnt_n   = '0;
         state_n = S_GAP;
         unique case (state)
            S_INIT: nxt_n = S_SAMP;
            S_SAMP: nxt_n = S_COMP;
            S_COMP: begin
               nxt_n     = S_LOGIC;
               cap_shift = 1'b1;
            end
            default: begin
               if (cyc_inc != ncyc_eff) begin
                  nxt_n = S_COMP;
                  cyc_n = cyc_inc;
               end else begin
                  rv_n   = 1'b1;
                  cyc_n  = '0;
                  conv_n = conv_inc;
                  if (sh_nconv != 8'd0 && conv_inc == sh_nconv) begin
                     state_n = S_IDLE;
                     done_n  = 1'b1;
                  end else begin
                     nxt_n = S_INIT;
                  end
               end
            end
         endcase
      end
   end

   // state, counters and shadow configuration registers
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state      <= S_IDLE;
         nxt        <= S_IDLE;
         cnt        <= '0;
         cyc        <= '0;
         conv       <= '0;
         sh_t_init  <= '0;
         sh_t_samp  <= '0;
         sh_t_comp  <= '0;
         sh_t_logic <= '0;
         sh_ncycles <= '0;
         sh_nconv   <= '0;
      end else begin
         state <= state_n;
         nxt   <= nxt_n;
         cnt   <= cnt_n;
         cyc   <= cyc_n;
         conv  <= conv_n;
         if (load) begin
            sh_t_init  <= cfg_t_init;
            sh_t_samp  <= cfg_t_samp;
            sh_t_comp  <= cfg_t_comp;
            sh_t_logic <= cfg_t_logic;
            sh_ncycles <= cfg_ncycles;
            sh_nconv   <= cfg_nconv;
         end
      end
   end

   // glitch-free strobes and status decoded from the next state
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         seq_init     <= 1'b0;
         seq_samp     <= 1'b0;
         seq_comp     <= 1'b0;
         seq_logic    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         seq_init     <= (state_n == S_INIT);
         seq_samp     <= (state_n == S_SAMP);
         seq_comp     <= (state_n == S_COMP);
         seq_logic    <= (state_n == S_LOGIC);
         busy         <= (state_n != S_IDLE);
         done         <= done_n;
         result_valid <= rv_n;
      end
   end

`ifdef SEQ_CAPTURE_EN
   logic [NBITS-1:0] cap;

   // comp_in settles during COMP, so it is sampled raw at the COMP end
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         cap    <= '0;
         result <= '0;
      end else begin
         if (cap_clr)
            cap <= '0;
         else if (cap_shift)
            cap <= {cap[NBITS-2:0], comp_in};
         if (rv_n)
            result <= cap;
      end
   end
`else
   logic unused_capture;

   // capture path absent: decisions are dropped
   assign unused_capture = ^{comp_in, cap_shift, cap_clr};
   assign result         = '0;
`endif

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: randomized scoreboard bench for seq_controller.
// Expected phase runs, result_valid and done tokens come from a schedule model.
module tb_seq_controller;

   logic        clk = 1'b0;
   logic        reset_b;
   logic        start;
   logic        abort;
   logic [7:0]  cfg_t_init;
   logic [7:0]  cfg_t_samp;
   logic [7:0]  cfg_t_comp;
   logic [7:0]  cfg_t_logic;
   logic [4:0]  cfg_ncycles;
   logic [7:0]  cfg_nconv;
   logic        comp_in;
   logic        seq_init;
   logic        seq_samp;
   logic        seq_comp;
   logic        seq_logic;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        result_valid;

   always #5 clk = ~clk;

   seq_controller #(.NBITS(16), .CNT_W(8)) dut (
      .clk          (clk),
      .reset_b      (reset_b),
      .start        (start),
      .abort        (abort),
      .cfg_t_init   (cfg_t_init),
      .cfg_t_samp   (cfg_t_samp),
      .cfg_t_comp   (cfg_t_comp),
      .cfg_t_logic  (cfg_t_logic),
      .cfg_ncycles  (cfg_ncycles),
      .cfg_nconv    (cfg_nconv),
      .comp_in      (comp_in),
      .seq_init     (seq_init),
      .seq_samp     (seq_samp),
      .seq_comp     (seq_comp),
      .seq_logic    (seq_logic),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .result_valid (result_valid)
   );

`ifdef SEQ_CAPTURE_EN
   localparam bit CAP_ON = 1'b1;
`else
   localparam bit CAP_ON = 1'b0;
`endif

   // observed key = {busy, init, samp, comp, logic}
   localparam logic [4:0] KI = 5'b11000;
   localparam logic [4:0] KS = 5'b10100;
   localparam logic [4:0] KC = 5'b10010;
   localparam logic [4:0] KL = 5'b10001;
   localparam logic [4:0] KG = 5'b10000;
   localparam int TK_PH   = 0;
   localparam int TK_RV   = 1;
   localparam int TK_DONE = 2;

   typedef struct {
      int          kind;
      logic [4:0]  key;
      int          len;
      logic [15:0] val;
   } tok_t;

   tok_t        exp_q[$];
   int          checks = 0;
   int          fails  = 0;
   bit          rnd [16384];
   int          m_pos;
   int          m_stop;
   int          m_comp2;
   int          m_samp;
   bit          m_push;
   logic [15:0] exp_result = 16'h0;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic check_tok(input int kind, input logic [4:0] key,
                            input int len, input logic [15:0] val);
      tok_t e;
      checks++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL sb_unexpected got kind=%0d key=%b len=%0d val=%h expected none",
                  kind, key, len, val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.key != key || e.len != len || e.val != val) begin
            fails++;
            $display("FAIL sb_token got kind=%0d key=%b len=%0d val=%h expected kind=%0d key=%b len=%0d val=%h",
                     kind, key, len, val, e.kind, e.key, e.len, e.val);
         end
      end
   endtask

   // model: one phase run of len cycles, clipped at the stop point
   task automatic add_ph(input logic [4:0] key, input int len);
      tok_t t;
      if (m_push && m_pos < m_stop) begin
         t.kind = TK_PH;
         t.key  = key;
         t.len  = (m_pos + len > m_stop) ? m_stop - m_pos : len;
         t.val  = 16'h0;
         exp_q.push_back(t);
      end
      m_pos += len;
   endtask

   // model: a pulse visible in the cycle at m_pos
   task automatic add_ev(input int kind, input logic [15:0] val);
      tok_t t;
      if (m_push && m_pos < m_stop) begin
         t.kind = kind;
         t.key  = 5'b0;
         t.len  = 0;
         t.val  = val;
         exp_q.push_back(t);
         if (kind == TK_RV)
            exp_result = val;
      end
   endtask

   // model: whole-run schedule from the latched configuration
   task automatic model_run(input int ti, input int ts, input int tc,
                            input int tl, input int ncyc, input int nconv,
                            input int nmodel, input int stop, input bit push,
                            input bit pat, output int full);
      int          ncy;
      int          nruns;
      logic [15:0] cap;
      ncy    = (ncyc == 0) ? 1 : ((ncyc > 16) ? 16 : ncyc);
      nruns  = (nconv == 0) ? nmodel : nconv;
      m_pos  = 0;
      m_stop = (stop < 0) ? 32'h7fffffff : stop;
      m_push = push;
      for (int k = 0; k < nruns; k++) begin
         cap = 16'h0;
         if (k > 0)
            add_ph(KG, 1);
         add_ph(KI, ti + 1);
         add_ph(KG, 1);
         if (k == 0)
            m_samp = m_pos;
         add_ph(KS, ts + 1);
         for (int j = 0; j < ncy; j++) begin
            add_ph(KG, 1);
            if (k == 0 && j == 1)
               m_comp2 = m_pos;
            add_ph(KC, tc + 1);
            if (pat)
               rnd[m_pos-1] = (j % 2 == 0);
            cap = {cap[14:0], rnd[m_pos-1]};
            add_ph(KG, 1);
            add_ph(KL, tl + 1);
         end
         add_ev(TK_RV, CAP_ON ? cap : 16'h0);
         if (nconv != 0 && k == nruns - 1)
            add_ev(TK_DONE, 16'h0);
      end
      full = m_pos;
   endtask

   // sel: 0 none, 1 abort in 2nd COMP, 2 reset mid-SAMP,
   //      3 abort near end, 4 abort at random cycle
   task automatic do_run(input int ti, input int ts, input int tc,
                         input int tl, input int ncyc, input int nconv,
                         input int nmodel, input int sel, input bit pat);
      int full;
      int stop;
      int lim;
      for (int i = 0; i < 16384; i++)
         rnd[i] = bit'($urandom_range(0, 1));
      model_run(ti, ts, tc, tl, ncyc, nconv, nmodel, -1, 1'b0, pat, full);
      stop = -1;
      if (sel == 1)
         stop = m_comp2 + 1;
      else if (sel == 2)
         stop = m_samp + 1;
      else if (sel == 3)
         stop = full - 2;
      else if (sel == 4)
         stop = $urandom_range(1, full);
      model_run(ti, ts, tc, tl, ncyc, nconv, nmodel, stop, 1'b1, pat, full);
      lim = (sel == 0) ? full : ((sel == 2) ? stop + 1 : stop);
      cfg_t_init  = 8'(ti);
      cfg_t_samp  = 8'(ts);
      cfg_t_comp  = 8'(tc);
      cfg_t_logic = 8'(tl);
      cfg_ncycles = 5'(ncyc);
      cfg_nconv   = 8'(nconv);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 0; c < lim; c++) begin
         if (sel == 2 && c == stop) begin
            start   = 1'b0;
            reset_b = 1'b0;
            #1;
            chk("reset_mid_outs",
                {seq_init, seq_samp, seq_comp, seq_logic, busy, done,
                 result_valid, result}, 32'h0);
            exp_result = 16'h0;
            #2;
            reset_b = 1'b1;
            break;
         end
         comp_in     = rnd[c];
         cfg_t_init  = 8'($urandom);
         cfg_t_samp  = 8'($urandom);
         cfg_t_comp  = 8'($urandom);
         cfg_t_logic = 8'($urandom);
         cfg_ncycles = 5'($urandom);
         cfg_nconv   = 8'($urandom);
         start       = ($urandom_range(0, 7) == 0);
         abort       = (sel != 0 && sel != 2 && c == stop - 1);
         @(posedge clk);
         #1;
         abort = 1'b0;
      end
      start = 1'b0;
      if (sel == 1 || sel == 3 || sel == 4) begin
         chk("abort_outs",
             {seq_init, seq_samp, seq_comp, seq_logic, busy, done, result_valid},
             32'h0);
         chk("abort_result", result, exp_result);
      end
      @(negedge clk);
      #1;
      chk("sb_drained", exp_q.size(), 0);
   endtask

   // monitor: run-length encode strobes, pop expected token per event
   initial begin
      logic [4:0] prev;
      logic [4:0] key;
      int         len;
      prev = 5'b0;
      len  = 0;
      forever begin
         @(negedge clk);
         key = {busy, seq_init, seq_samp, seq_comp, seq_logic};
         if (key != prev) begin
            if (prev[4])
               check_tok(TK_PH, prev, len, 16'h0);
            prev = key;
            len  = 1;
         end else begin
            len++;
         end
         if (result_valid)
            check_tok(TK_RV, 5'b0, 0, result);
         if (done)
            check_tok(TK_DONE, 5'b0, 0, 16'h0);
      end
   end

   initial begin
      reset_b     = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      cfg_t_init  = 8'h0;
      cfg_t_samp  = 8'h0;
      cfg_t_comp  = 8'h0;
      cfg_t_logic = 8'h0;
      cfg_ncycles = 5'h0;
      cfg_nconv   = 8'h0;
      comp_in     = 1'b0;
      #2;
      chk("reset_outs",
          {seq_init, seq_samp, seq_comp, seq_logic, busy, done,
           result_valid, result}, 32'h0);
      repeat (3) @(negedge clk);
      reset_b = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_after_reset", {busy, seq_init, done}, 32'h0);

      do_run(1, 3, 0, 0, 2, 1, 0, 0, 1'b0);

      do_run(1, 3, 0, 0, 2, 1, 0, 0, 1'b1);
      chk("cap_pair", result, CAP_ON ? 32'h0002 : 32'h0);
      do_run(1, 3, 0, 0, 16, 1, 0, 0, 1'b1);
      chk("cap_alt16", result, CAP_ON ? 32'hAAAA : 32'h0);

      do_run(2, 3, 1, 0, 3, 3, 0, 0, 1'b0);

      do_run(0, 1, 2, 0, 4, 1, 0, 1, 1'b0);
      do_run(1, 3, 0, 0, 2, 1, 0, 0, 1'b1);
      chk("cap_after_abort", result, CAP_ON ? 32'h0002 : 32'h0);

      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      chk("start_abort_idle", {busy, seq_init}, 32'h0);
      start = 1'b0;
      abort = 1'b0;

      do_run(0, 0, 0, 0, 0, 2, 0, 0, 1'b0);
      do_run(0, 0, 0, 0, 31, 1, 0, 0, 1'b0);
      do_run(255, 0, 0, 255, 1, 1, 0, 0, 1'b0);

      repeat (10) begin
         do_run($urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 20), $urandom_range(1, 3), 0,
                ($urandom_range(0, 2) == 0) ? 4 : 0, 1'b0);
      end

      do_run($urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(1, 2), 0, 301, 3, 1'b0);

      do_run(1, 3, 0, 0, 2, 1, 0, 2, 1'b0);
      chk("result_after_reset", result, 32'h0);
      do_run(1, 3, 0, 0, 2, 2, 0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
